// File: rtl/pixel_pkg.sv
// Shared types and constants for the 2x2 pixel-sensor model: frame states,
// default phase durations and the saturating charge-accumulate helper.
package pixel_pkg;

    typedef enum logic [1:0] {
        ST_ERASE   = 2'd0,
        ST_EXPOSE  = 2'd1,
        ST_CONVERT = 2'd2,
        ST_READ    = 2'd3
    } state_t;

    localparam int ERASE_CYC_DEF  = 5;
    localparam int EXPOSE_CYC_DEF = 255;
    localparam int CONVERT_CYC    = 256;
    localparam int READ_CYC       = 4;
    localparam int NUM_PIXELS     = 4;
    localparam int CNT_W          = 16;
    localparam int ACC_W          = 16;
    localparam int PIX_W          = 8;

    // Charge never wraps: a carry out clamps the accumulator at full scale.
    function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] acc,
                                                 input logic [PIX_W-1:0] light);
        logic [ACC_W:0] sum;
        sum = {1'b0, acc} + {{(ACC_W-PIX_W+1){1'b0}}, light};
        if (sum[ACC_W]) begin
            return {ACC_W{1'b1}};
        end else begin
            return sum[ACC_W-1:0];
        end
    endfunction

endpackage

// File: rtl/pixel_sensor.sv
// One pixel cell: integrates light into a saturating charge accumulator and
// latches its level from the shared ramp, then drives the shared bus when selected.
module pixel_sensor
    import pixel_pkg::*;
#(
    parameter int LIGHT = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             erase,
    input  logic             expose,
    input  logic             convert,
    input  logic [PIX_W-1:0] ramp,
    input  logic             read,
    output tri   [PIX_W-1:0] data
);

    localparam logic [PIX_W-1:0] LIGHT_V = PIX_W'(LIGHT);

    logic [ACC_W-1:0] acc;
    logic [PIX_W-1:0] mem;
    logic [PIX_W-1:0] level;

    assign level = acc[ACC_W-1:ACC_W-PIX_W];

    // Charge accumulator: cleared in ERASE, integrates in EXPOSE, held otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= {ACC_W{1'b0}};
        end else if (erase) begin
            acc <= {ACC_W{1'b0}};
        end else if (expose) begin
            acc <= sat_add(acc, LIGHT_V);
        end else begin
            acc <= acc;
        end
    end

    // Single-slope conversion: the ramp crosses every level exactly once.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem <= {PIX_W{1'b0}};
        end else if (convert && (ramp == level)) begin
            mem <= ramp;
        end else begin
            mem <= mem;
        end
    end

    assign data = read ? mem : {PIX_W{1'bz}};

endmodule

// File: rtl/pixel_top.sv
// 2x2 pixel-sensor top: free-running frame FSM, shared ramp counter and a
// registered one-hot read select that lets exactly one pixel drive DATA.
module pixel_top
    import pixel_pkg::*;
#(
    parameter int ERASE_CYC  = ERASE_CYC_DEF,
    parameter int EXPOSE_CYC = EXPOSE_CYC_DEF,
    parameter int LIGHT0     = 51,
    parameter int LIGHT1     = 102,
    parameter int LIGHT2     = 153,
    parameter int LIGHT3     = 204
) (
    input  logic             CLK,
    input  logic             RESET,
    output tri   [PIX_W-1:0] DATA
);

    localparam logic [CNT_W-1:0] ERASE_LAST   = CNT_W'(ERASE_CYC - 1);
    localparam logic [CNT_W-1:0] EXPOSE_LAST  = CNT_W'(EXPOSE_CYC - 1);
    localparam logic [CNT_W-1:0] CONVERT_LAST = CNT_W'(CONVERT_CYC - 1);
    localparam logic [CNT_W-1:0] READ_LAST    = CNT_W'(READ_CYC - 1);
    localparam int LIGHTS [NUM_PIXELS] = '{LIGHT0, LIGHT1, LIGHT2, LIGHT3};

    state_t                  state;
    state_t                  next_state;
    logic [CNT_W-1:0]        cyc;
    logic [CNT_W-1:0]        next_cyc;
    logic                    last_cyc;
    logic [PIX_W-1:0]        ramp;
    logic [NUM_PIXELS-1:0]   read_sel;
    logic [NUM_PIXELS-1:0]   read_sel_next;
    logic                    erase;
    logic                    expose;
    logic                    convert;

    // Frame state register.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= ST_ERASE;
        end else begin
            state <= next_state;
        end
    end

    // End-of-phase detect against each phase's duration.
    always_comb begin
        last_cyc = 1'b0;
        case (state)
            ST_ERASE:   last_cyc = (cyc == ERASE_LAST);
            ST_EXPOSE:  last_cyc = (cyc == EXPOSE_LAST);
            ST_CONVERT: last_cyc = (cyc == CONVERT_LAST);
            ST_READ:    last_cyc = (cyc == READ_LAST);
            default:    last_cyc = 1'b1;
        endcase
    end

    // Next-state logic: strict ERASE -> EXPOSE -> CONVERT -> READ ring.
    always_comb begin
        next_state = state;
        case (state)
            ST_ERASE:   next_state = last_cyc ? ST_EXPOSE  : ST_ERASE;
            ST_EXPOSE:  next_state = last_cyc ? ST_CONVERT : ST_EXPOSE;
            ST_CONVERT: next_state = last_cyc ? ST_READ    : ST_CONVERT;
            ST_READ:    next_state = last_cyc ? ST_ERASE   : ST_READ;
            default:    next_state = ST_ERASE;
        endcase
    end

    // Phase strobes to the pixel cells.
    always_comb begin
        erase   = 1'b0;
        expose  = 1'b0;
        convert = 1'b0;
        case (state)
            ST_ERASE:   erase   = 1'b1;
            ST_EXPOSE:  expose  = 1'b1;
            ST_CONVERT: convert = 1'b1;
            ST_READ:    erase   = 1'b0;
            default:    erase   = 1'b0;
        endcase
    end

    // Cycle count within the current phase restarts at every phase change.
    always_comb begin
        if (last_cyc) begin
            next_cyc = {CNT_W{1'b0}};
        end else begin
            next_cyc = cyc + CNT_W'(1);
        end
    end

    // Phase cycle counter.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            cyc <= {CNT_W{1'b0}};
        end else begin
            cyc <= next_cyc;
        end
    end

    // Ramp sits at 0 outside CONVERT so the first CONVERT cycle compares against 0.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            ramp <= {PIX_W{1'b0}};
        end else if (state == ST_CONVERT) begin
            ramp <= ramp + PIX_W'(1);
        end else begin
            ramp <= {PIX_W{1'b0}};
        end
    end

    // Select is decoded from the upcoming state so it is a clean register during READ.
    always_comb begin
        if (next_state == ST_READ) begin
            read_sel_next = NUM_PIXELS'(1) << next_cyc[1:0];
        end else begin
            read_sel_next = {NUM_PIXELS{1'b0}};
        end
    end

    // Registered one-hot read select.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            read_sel <= {NUM_PIXELS{1'b0}};
        end else begin
            read_sel <= read_sel_next;
        end
    end

    for (genvar i = 0; i < NUM_PIXELS; i++) begin : g_pix
        pixel_sensor #(
            .LIGHT (LIGHTS[i])
        ) u_pix (
            .clk     (CLK),
            .rst     (RESET),
            .erase   (erase),
            .expose  (expose),
            .convert (convert),
            .ramp    (ramp),
            .read    (read_sel[i]),
            .data    (DATA)
        );
    end

endmodule

// File: tb/tb_pixel_top.sv
// Scoreboard bench for pixel_top: three parameterisations share a randomly
// pulsed reset; a frame-level model predicts DATA every cycle.
module tb_pixel_top;

    logic clk = 1'b0;
    logic rst = 1'b1;
    tri [7:0] data_def;
    tri [7:0] data_ovr;
    tri [7:0] data_dim;

    always #5 clk = ~clk;

    pixel_top u_def (.CLK(clk), .RESET(rst), .DATA(data_def));
    pixel_top #(.EXPOSE_CYC(300), .LIGHT0(0), .LIGHT1(255)) u_ovr (.CLK(clk), .RESET(rst), .DATA(data_ovr));
    pixel_top #(.LIGHT2(1)) u_dim (.CLK(clk), .RESET(rst), .DATA(data_dim));

    typedef struct {
        int         t;
        logic [7:0] d;
        logic [7:0] o;
        logic [7:0] m;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int failures = 0;
    int t = 0;

    // Frame model: period = erase + expose + 256 + 4; readout k shows floor(min(L*X,65535)/256).
    function automatic logic [7:0] exp_data(input int tc, input int e, input int x,
                                            input int l0, input int l1, input int l2, input int l3);
        int lts[4];
        int rd;
        int ph;
        int acc;
        lts = '{l0, l1, l2, l3};
        rd = e + x + 256;
        ph = tc % (rd + 4);
        if (ph < rd) return 8'hzz;
        acc = lts[ph - rd] * x;
        if (acc > 65535) acc = 65535;
        return 8'(acc / 256);
    endfunction

    task automatic check(input string name, input int tc, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%h expected=%h", name, tc, got, exp);
        end
    endtask

    task automatic run(input int n, input bit r);
        exp_t e;
        repeat (n) begin
            @(negedge clk);
            rst = r;
            @(posedge clk);
            #1;
            if (r) t = 0;
            else t = t + 1;
            e.t = t;
            e.d = exp_data(t, 5, 255, 51, 102, 153, 204);
            e.o = exp_data(t, 5, 300, 0, 255, 153, 204);
            e.m = exp_data(t, 5, 255, 51, 102, 1, 204);
            sb.push_back(e);
        end
    endtask

    // Monitor: compares every presented bus value against the queued prediction.
    always @(negedge clk) begin
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check("data_default", e.t, data_def, e.d);
            check("data_override", e.t, data_ovr, e.o);
            check("data_dim", e.t, data_dim, e.m);
        end
    end

    initial begin
        run(1, 1'b1);
        run(2400, 1'b0);
        run(1, 1'b1);
        run(300, 1'b0);
        run(1, 1'b1);
        run(1200, 1'b0);
        for (int k = 0; k < 4; k++) begin
            run(int'($urandom_range(1, 3)), 1'b1);
            run(int'($urandom_range(50, 1200)), 1'b0);
        end
        run(1, 1'b1);
        run(1150, 1'b0);
        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain pending=%0d expected=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
